// File: rtl/thread_fetch_scheduler.sv
// Hardware-thread fetch scheduler: picks which hart's PC goes to the I-cache
// each cycle. Threads take turns in round-robin order, and each turn lasts a
// fixed number of accepted fetches. A thread that is inactive or stalled is
// skipped.
module thread_fetch_scheduler #(
  parameter int NUM_THREADS     = 2,
  parameter int NUM_THREADS_LOG = 1,
  parameter int QUANTUM         = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [NUM_THREADS-1:0]     thread_active_i,
  input  logic [NUM_THREADS-1:0]     thread_stall_i,
  input  logic                       fetch_ready_i,
  output logic                       fetch_valid_o,
  output logic [NUM_THREADS_LOG-1:0] fetch_tid_o,
  output logic                       switch_o,
  output logic                       idle_o
);

  localparam int CNT_W = $clog2(QUANTUM + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                     state_q;
  logic [NUM_THREADS_LOG-1:0] cur_tid_q;
  logic [CNT_W-1:0]           cnt_q;
  logic                       switch_q;

  logic [NUM_THREADS-1:0]     eligible;
  logic [NUM_THREADS_LOG-1:0] next_tid;
  logic                       other_exists;
  logic                       cur_eligible;
  logic                       any_eligible;
  logic                       accept;

  // Reduce a thread offset modulo the thread count so the scan wraps past the last hart
  function automatic logic [NUM_THREADS_LOG-1:0] wrap_tid(input int unsigned v);
    return NUM_THREADS_LOG'(v % NUM_THREADS);
  endfunction

  assign eligible      = thread_active_i & ~thread_stall_i;
  assign cur_eligible  = eligible[cur_tid_q];
  assign any_eligible  = |eligible;
  assign fetch_valid_o = (state_q == RUN) & cur_eligible & ~flush_i;
  assign accept        = fetch_valid_o & fetch_ready_i;
  assign fetch_tid_o   = cur_tid_q;
  assign switch_o      = switch_q;
  assign idle_o        = (state_q == IDLE);

  // Find the nearest eligible thread after the current one. The scan runs from far to near so the nearest candidate is written last and wins.
  always_comb begin
    next_tid     = cur_tid_q;
    other_exists = 1'b0;
    for (int k = NUM_THREADS - 1; k >= 1; k--) begin
      if (eligible[wrap_tid(int'(cur_tid_q) + k)]) begin
        next_tid     = wrap_tid(int'(cur_tid_q) + k);
        other_exists = 1'b1;
      end
    end
  end

  // Scheduler FSM: quantum counting, thread hand-off and the registered switch pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cur_tid_q <= '0;
      cnt_q     <= '0;
      switch_q  <= 1'b0;
    end else begin
      switch_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (any_eligible) begin
            state_q <= RUN;
          end
          if (!cur_eligible && other_exists) begin
            cur_tid_q <= next_tid;
            switch_q  <= 1'b1;
          end
        end
        RUN: begin
          if (flush_i) begin
            cnt_q <= '0;
          end else if (!any_eligible) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (!cur_eligible) begin
            cur_tid_q <= next_tid;
            switch_q  <= 1'b1;
            cnt_q     <= '0;
          end else if (accept && (cnt_q == CNT_W'(QUANTUM - 1))) begin
            cnt_q <= '0;
            if (other_exists) begin
              cur_tid_q <= next_tid;
              switch_q  <= 1'b1;
            end
          end else if (accept) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// Self-checking bench for thread_fetch_scheduler. A behavioural scheduler model is kept in plain integers.
// Directed scenarios pin that model with literal expectations, and a randomized phase follows them.
module tb_thread_fetch_scheduler;

  localparam int NT  = 2;
  localparam int NTL = 1;
  localparam int Q   = 8;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b1;
  logic           flush_i = 1'b0;
  logic [NT-1:0]  thread_active_i = '0;
  logic [NT-1:0]  thread_stall_i = '0;
  logic           fetch_ready_i = 1'b0;
  logic           fetch_valid_o;
  logic [NTL-1:0] fetch_tid_o;
  logic           switch_o;
  logic           idle_o;

  int passCount  = 0;
  int checkCount = 0;

  // Behavioural model state: idle flag, current thread, accepted count in quantum, switch pulse
  bit m_idle = 1'b1;
  int m_tid  = 0;
  int m_cnt  = 0;
  bit m_sw   = 1'b0;
  bit n_idle;
  int n_tid;
  int n_cnt;
  bit n_sw;

  thread_fetch_scheduler #(
    .NUM_THREADS(NT),
    .NUM_THREADS_LOG(NTL),
    .QUANTUM(Q)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .flush_i(flush_i),
    .thread_active_i(thread_active_i),
    .thread_stall_i(thread_stall_i),
    .fetch_ready_i(fetch_ready_i),
    .fetch_valid_o(fetch_valid_o),
    .fetch_tid_o(fetch_tid_o),
    .switch_o(switch_o),
    .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit elig(int t);
    return thread_active_i[t] & ~thread_stall_i[t];
  endfunction

  // Nearest eligible thread after cur in round-robin order, or -1 if none
  function automatic int pickOther(int cur);
    for (int k = 1; k < NT; k++) begin
      if (elig((cur + k) % NT)) return (cur + k) % NT;
    end
    return -1;
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic checkAll();
    bit expValid;
    expValid = !m_idle && elig(m_tid) && !flush_i;
    checkOutput("model_valid", int'(fetch_valid_o), int'(expValid));
    checkOutput("model_tid", int'(fetch_tid_o), m_tid);
    checkOutput("model_switch", int'(switch_o), int'(m_sw));
    checkOutput("model_idle", int'(idle_o), int'(m_idle));
  endtask

  // Next model state from the scheduling rules applied to this cycle's inputs
  task automatic modelStep();
    int other;
    bit any;
    bit acc;
    other  = pickOther(m_tid);
    any    = elig(m_tid) || (other >= 0);
    acc    = !m_idle && elig(m_tid) && !flush_i && fetch_ready_i;
    n_idle = m_idle;
    n_tid  = m_tid;
    n_cnt  = m_cnt;
    if (m_idle) begin
      if (any) n_idle = 1'b0;
      if (!elig(m_tid) && other >= 0) n_tid = other;
      n_cnt = 0;
    end else if (flush_i) begin
      n_cnt = 0;
    end else if (!any) begin
      n_idle = 1'b1;
      n_cnt  = 0;
    end else if (!elig(m_tid)) begin
      n_tid = other;
      n_cnt = 0;
    end else if (acc && m_cnt == Q - 1) begin
      n_cnt = 0;
      if (other >= 0) n_tid = other;
    end else if (acc) begin
      n_cnt = m_cnt + 1;
    end
    n_sw = (n_tid != m_tid);
    if (!rst_ni) begin
      n_idle = 1'b1;
      n_tid  = 0;
      n_cnt  = 0;
      n_sw   = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [NT-1:0] act, input logic [NT-1:0] stl,
                               input logic rdy, input logic fl);
    rst_ni          = rst;
    thread_active_i = act;
    thread_stall_i  = stl;
    fetch_ready_i   = rdy;
    flush_i         = fl;
    if (!rst) begin
      m_idle = 1'b1;
      m_tid  = 0;
      m_cnt  = 0;
      m_sw   = 1'b0;
    end
    #1;
  endtask

  // One clock: compare against the model, advance the model, cross the edge
  task automatic cycle();
    checkAll();
    modelStep();
    @(posedge clk_i);
    m_idle = n_idle;
    m_tid  = n_tid;
    m_cnt  = n_cnt;
    m_sw   = n_sw;
    #1;
  endtask

  task automatic doReset(input logic [NT-1:0] act, input logic [NT-1:0] stl);
    applyStimulus(1'b0, act, stl, 1'b1, 1'b0);
    cycle();
  endtask

  initial begin
    int runIdx, sw1, sw2, validRun, swCount, tidNonZero, acc1, idleGood, firstSw;
    bit done;

    #2;
    applyStimulus(1'b0, 2'b11, 2'b00, 1'b1, 1'b0);
    checkOutput("reset_idle", int'(idle_o), 1);
    checkOutput("reset_valid", int'(fetch_valid_o), 0);
    checkOutput("reset_tid", int'(fetch_tid_o), 0);
    checkOutput("reset_switch", int'(switch_o), 0);
    cycle();

    $display("[TB] round robin with both threads eligible");
    applyStimulus(1'b1, 2'b11, 2'b00, 1'b1, 1'b0);
    cycle();
    runIdx = 0; sw1 = 0; sw2 = 0; validRun = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 2'b11, 2'b00, 1'b1, 1'b0);
      runIdx++;
      if (fetch_valid_o) validRun++;
      if (switch_o) begin
        if (sw1 == 0) sw1 = runIdx;
        else if (sw2 == 0) sw2 = runIdx;
      end
      if (runIdx == 9) checkOutput("rr_tid_second_quantum", int'(fetch_tid_o), 1);
      if (runIdx == 17) checkOutput("rr_tid_third_quantum", int'(fetch_tid_o), 0);
      cycle();
    end
    checkOutput("rr_first_switch_cycle", sw1, 9);
    checkOutput("rr_second_switch_cycle", sw2, 17);
    checkOutput("rr_valid_cycles", validRun, 20);

    $display("[TB] single active thread");
    doReset(2'b01, 2'b00);
    applyStimulus(1'b1, 2'b01, 2'b00, 1'b1, 1'b0);
    cycle();
    swCount = 0; tidNonZero = 0; validRun = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 2'b01, 2'b00, 1'b1, 1'b0);
      if (switch_o) swCount++;
      if (fetch_tid_o != 0) tidNonZero++;
      if (fetch_valid_o) validRun++;
      cycle();
    end
    checkOutput("solo_switch_count", swCount, 0);
    checkOutput("solo_tid_nonzero", tidNonZero, 0);
    checkOutput("solo_valid_cycles", validRun, 20);

    $display("[TB] stall of the running thread");
    doReset(2'b11, 2'b00);
    applyStimulus(1'b1, 2'b11, 2'b00, 1'b1, 1'b0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'b11, 2'b00, 1'b1, 1'b0);
      cycle();
    end
    applyStimulus(1'b1, 2'b11, 2'b01, 1'b1, 1'b0);
    checkOutput("stall_valid_drop", int'(fetch_valid_o), 0);
    cycle();
    applyStimulus(1'b1, 2'b11, 2'b01, 1'b1, 1'b0);
    checkOutput("stall_tid_moved", int'(fetch_tid_o), 1);
    checkOutput("stall_switch_pulse", int'(switch_o), 1);
    acc1 = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (i > 0) applyStimulus(1'b1, 2'b11, (i < 3) ? 2'b01 : 2'b00, 1'b1, 1'b0);
      if (fetch_tid_o == 0) done = 1'b1;
      else begin
        if (fetch_valid_o && fetch_ready_i) acc1++;
        cycle();
      end
    end
    checkOutput("stall_return_seen", int'(done), 1);
    checkOutput("stall_thread1_accepts", acc1, 8);

    $display("[TB] both threads stalled");
    doReset(2'b11, 2'b11);
    idleGood = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'b11, 2'b11, 1'b1, 1'b0);
      if (idle_o && !fetch_valid_o) idleGood++;
      cycle();
    end
    checkOutput("allstall_idle_cycles", idleGood, 5);
    applyStimulus(1'b1, 2'b11, 2'b01, 1'b1, 1'b0);
    cycle();
    applyStimulus(1'b1, 2'b11, 2'b01, 1'b1, 1'b0);
    checkOutput("release_idle", int'(idle_o), 0);
    checkOutput("release_tid", int'(fetch_tid_o), 1);
    checkOutput("release_valid", int'(fetch_valid_o), 1);
    cycle();

    $display("[TB] flush mid quantum");
    doReset(2'b11, 2'b00);
    applyStimulus(1'b1, 2'b11, 2'b00, 1'b1, 1'b0);
    cycle();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 2'b11, 2'b00, 1'b1, 1'b0);
      cycle();
    end
    applyStimulus(1'b1, 2'b11, 2'b00, 1'b1, 1'b1);
    checkOutput("flush_valid", int'(fetch_valid_o), 0);
    cycle();
    applyStimulus(1'b1, 2'b11, 2'b00, 1'b1, 1'b0);
    checkOutput("flush_tid_held", int'(fetch_tid_o), 0);
    acc1 = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (i > 0) applyStimulus(1'b1, 2'b11, 2'b00, 1'b1, 1'b0);
      if (fetch_tid_o != 0) done = 1'b1;
      else begin
        if (fetch_valid_o && fetch_ready_i) acc1++;
        cycle();
      end
    end
    checkOutput("flush_switch_seen", int'(done), 1);
    checkOutput("flush_restart_accepts", acc1, 8);

    $display("[TB] toggling ready then async reset");
    doReset(2'b11, 2'b00);
    applyStimulus(1'b1, 2'b11, 2'b00, 1'b1, 1'b0);
    cycle();
    firstSw = -1;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b1, 2'b11, 2'b00, (i % 2) == 0, 1'b0);
      if (switch_o && firstSw < 0) firstSw = i;
      cycle();
    end
    checkOutput("toggle_switch_cycle", firstSw, 15);
    applyStimulus(1'b0, 2'b11, 2'b00, 1'b1, 1'b0);
    checkOutput("async_reset_tid", int'(fetch_tid_o), 0);
    checkOutput("async_reset_valid", int'(fetch_valid_o), 0);
    checkOutput("async_reset_idle", int'(idle_o), 1);
    cycle();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(199) != 0,
                    ($urandom_range(3) == 0) ? NT'($urandom_range(3)) : 2'b11,
                    {$urandom_range(3) == 0, $urandom_range(3) == 0},
                    $urandom_range(3) != 0,
                    $urandom_range(15) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/thread_fetch_scheduler.md
Name: thread_fetch_scheduler

Overview:
Per-cycle hardware-thread selector sitting directly upstream of the frontend fetch request path in the multithreaded core (NUM_THREADS=2 configuration). It picks which hart's PC the frontend issues to the I-cache. Selection is round-robin with a fixed time quantum, and a thread is skipped while it is inactive or stalled. It drives a tid and a valid/ready handshake consumed by the frontend's PC-select stage.

Parameters:
NUM_THREADS, 2, number of hardware threads; must be ≥2.
NUM_THREADS_LOG, 1, tid width; equals log2(NUM_THREADS).
QUANTUM, 8, max accepted fetches per thread before a forced switch; range 1..255.

Ports:
clk_i  input  1  core clock
rst_ni  input  1  asynchronous active-low reset
flush_i  input  1  global frontend flush; kills this cycle's request
thread_active_i  input  NUM_THREADS  bit t=1: hart t enabled (out of reset, not halted)
thread_stall_i  input  NUM_THREADS  bit t=1: hart t blocked (I-cache miss, fence, redirect pending)
fetch_ready_i  input  1  frontend accepts request this cycle
fetch_valid_o  output  1  request for fetch_tid_o is valid
fetch_tid_o  output  NUM_THREADS_LOG  selected hart
switch_o  output  1  one-cycle pulse: fetch_tid_o changed this cycle
idle_o  output  1  no hart eligible (FSM in IDLE)

Behaviour:
- Reset (async on rst_ni low):
  - state=IDLE, cur_tid_q=0, cnt_q=0, switch_o=0.
  - fetch_valid_o=0, idle_o=1.
- eligible[t] = thread_active_i[t] & ~thread_stall_i[t].
- Output timing:
  - fetch_tid_o = cur_tid_q (registered).
  - fetch_valid_o = (state==RUN) & eligible[cur_tid_q] & ~flush_i (combinational from regs and inputs).
  - idle_o = (state==IDLE).
- Handshake: a fetch is accepted when fetch_valid_o & fetch_ready_i. fetch_valid_o may drop without acceptance if the thread stalls; the frontend must not rely on it being sticky.
- next_tid: first eligible thread scanning cur_tid_q+1, cur_tid_q+2, … modulo NUM_THREADS (wraps NUM_THREADS-1 → 0). The scan excludes cur_tid_q; "other" means an eligible thread ≠ cur_tid_q exists.
- FSM IDLE:
  - If any eligible: go to RUN.
  - cur_tid_q ← eligible[cur_tid_q] ? cur_tid_q : next_tid.
  - cnt_q ← 0.
  - switch_o=1 next cycle iff tid changed.
- FSM RUN, priority order each cycle:
  1. flush_i: cnt_q ← 0, tid held, no acceptance counted.
  2. No eligible thread: go to IDLE, cnt_q ← 0.
  3. ~eligible[cur_tid_q] and other exists: cur_tid_q ← next_tid, cnt_q ← 0. Bubble is 0 cycles of lost opportunity beyond the current one.
  4. Accept and cnt_q==QUANTUM-1:
     - If other exists: cur_tid_q ← next_tid, cnt_q ← 0.
     - Else: stay on the current thread, cnt_q ← 0 (quantum restarts, no switch).
  5. Accept otherwise: cnt_q ← cnt_q+1.
  6. No accept: hold.
- switch_o is registered: 1 in the cycle after cur_tid_q updates to a different value, else 0.
- cnt_q width is clog2(QUANTUM+1); it never exceeds QUANTUM-1.
- A thread may change eligibility in the same cycle as acceptance. The acceptance counts, and rule 3 or 4 is evaluated on current-cycle eligibility.
- Reset mid-operation: all state returns to reset values immediately. No request is emitted until rst_ni is high and a thread is eligible.

Test Plan:
- Reset, both active, no stalls, fetch_ready_i=1 constantly:
  - tid 0 for 8 accepts, then tid 1 for 8, then 0 again.
  - switch_o pulses on cycles 9 and 17 after entering RUN.
  - fetch_valid_o continuously 1.
- Thread 1 inactive, ready=1 for 20 cycles: tid stays 0, cnt wraps every 8, switch_o never asserts.
- tid 0 running at cnt=3, thread_stall_i[0] rises:
  - fetch_valid_o=0 that cycle.
  - Next cycle tid=1, cnt=0, switch_o=1.
  - Stall released later: tid 1 completes its 8 accepts before returning to 0.
- Both stalled for 5 cycles:
  - idle_o=1 and fetch_valid_o=0 throughout.
  - Release thread 1 only: RUN with tid=1 one cycle later.
- flush_i asserted at cnt=6 with ready=1: no accept counted, cnt=0, tid unchanged, fetch_valid_o=0 in the flush cycle.
- fetch_ready_i toggling 1,0,1,0: cnt advances only on accept cycles; switch occurs after the 8th accept (16 cycles). Then assert rst_ni low mid-run: tid=0, cnt=0, fetch_valid_o=0 asynchronously.
